div_ctrl: RTL and testbench
===========================

# div_ctrl

Signed/unsigned divide sequencer wrapping the multicycle unsigned divider core of the ALU datapath. It accepts a divide request from the control unit, conditions operands (absolute values, zero check), launches the core, waits for its result, applies sign correction and commits quotient/remainder into the architectural HI/LO registers. It also serves MTHI/MTLO writes and MFHI/MFLO reads, and reports divide-by-zero and core-timeout exceptions.

## Interface
- `TIMEOUT`, default 63: maximum cycles in WAIT before abort. Range 1..63; 6-bit counter.
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  divide request pulse, sampled in IDLE only
- `is_signed`  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with `start`
- `a`  in  32  dividend (from A)
- `b`  in  32  divisor (from B)
- `hi_we` / `lo_we`  in  1  MTHI / MTLO write enables, honoured in IDLE only
- `wdata`  in  32  MTHI/MTLO data
- `core_dividend` / `core_divisor`  out  32  unsigned operands to core
- `core_start`  out  1  one-cycle launch pulse to core
- `core_done`  in  1  core result valid
- `core_q` / `core_r`  in  32  unsigned quotient / remainder from core
- `hi` / `lo`  out  32  architectural HI / LO (MFHI/MFLO source)
- `busy`  out  1  high from accepted `start` until `done`
- `done`  out  1  one-cycle completion pulse
- `erro`  out  8  0xFF for one cycle (with `done`) on divide by zero, else 0x00
- `timeout`  out  1  one-cycle pulse (with `done`) on core timeout

## Operation
- States: IDLE, PREP, LAUNCH, WAIT, FIX.
- IDLE: on `start`: latch `a`, `b`, `is_signed`, `busy`<=1, go PREP. `hi_we`/`lo_we` in IDLE write `wdata` to HI/LO; if `start` coincides, writes occur and divide still launches (divide result overwrites later).
- PREP: if latched `b`==0: `done`=1, `erro`=0xFF, HI/LO unchanged, `busy`<=0, back to IDLE. Else register `core_dividend`=|a|, `core_divisor`=|b| (signed), or raw values (unsigned); record `qneg`=a[31]^b[31], `rneg`=a[31] (signed only, else 0). Go LAUNCH.
- LAUNCH: `core_start`=1 for exactly this cycle; clear timeout counter; go WAIT.
- WAIT: on `core_done` latch `core_q`/`core_r`, go FIX. Counter increments each cycle; reaching TIMEOUT: `done`=1, `timeout`=1, HI/LO unchanged, go IDLE.
- FIX: LO<= `qneg` ? -q : q; HI<= `rneg` ? -r : r (32-bit two's complement, wrap). `done`=1 next cycle with updated HI/LO visible; `busy`<=0; go IDLE.
- Identities: remainder sign follows dividend; |HI| < |b|; a == LO*b + HI (mod 2^32).
- `start`, `hi_we`, `lo_we` outside IDLE: ignored, no side effects.
- `core_done` outside WAIT: ignored.
- |0x80000000| = 0x80000000 (unsigned interpretation to core).

## Timing
- Reset (async assert, sync deassert upstream): state IDLE; `hi`,`lo`,`core_dividend`,`core_divisor`=0; `core_start`,`busy`,`done`,`timeout`=0; `erro`=0x00.
- Reset mid-operation: abort immediately, HI/LO cleared, no `done`.
- `start` sampled edge E0; PREP cycle 1; `core_start` high cycle 2; `done` high cycle N+4 where core asserts `core_done` N cycles after `core_start` (N>=1). HI/LO update on the same edge that raises `done`.
- Divide by zero: `done`+`erro` high in cycle 2 (two cycles after `start`).
- Next `start` accepted the cycle `done` is high (state already IDLE).

## Configuration
- `DIVCTRL_OVF_DETECT_EN`: when defined, signed 0x80000000 / 0xFFFFFFFF is detected in PREP: no core launch, `done`=1 with `erro`=0xFF in cycle 2, HI/LO unchanged. When undefined, it runs normally and commits LO=0x80000000, HI=0x00000000.

## Test plan
- Unsigned 100 / 7 -> after core done: LO=14, HI=2, `done` one cycle, `erro`=0x00, latency N+4.
- Signed -7 / 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); 7 / -2 -> LO=-3, HI=1.
- Divisor 0 with HI=LO=0x12345678 preset via MTHI/MTLO -> `erro`=0xFF and `done` in cycle 2, HI/LO unchanged, `core_start` never asserted.
- 0x80000000 / 0xFFFFFFFF signed -> with macro: `erro`=0xFF, HI/LO unchanged; without: LO=0x80000000, HI=0.
- Core model never asserts `core_done`, TIMEOUT=10 -> `timeout`+`done` 10 cycles after WAIT entry, HI/LO unchanged, new `start` accepted.
- Reset low during WAIT, and `start`/`hi_we` pulsed while busy -> on reset all outputs 0, state IDLE; busy-time requests ignored, HI unchanged.

Source files
------------

// File: rtl/div_ctrl.sv
// Signed/unsigned divide sequencer around a multicycle unsigned divider core; owns HI/LO.
// Optional macro DIVCTRL_OVF_DETECT_EN traps signed 0x80000000 / -1 instead of running it.
module div_ctrl #(
  parameter int unsigned TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] core_dividend,
  output logic [31:0] core_divisor,
  output logic        core_start,
  input  logic        core_done,
  input  logic [31:0] core_q,
  input  logic [31:0] core_r,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic [7:0]  erro,
  output logic        timeout
);

  typedef enum logic [2:0] {IDLE, PREP, LAUNCH, WAIT, FIX} state_t;

  localparam logic [5:0] CNT_LAST = 6'(TIMEOUT - 1);

  state_t      state;
  logic [31:0] a_q, b_q, q_q, r_q;
  logic        sgn_q, qneg, rneg;
  logic [5:0]  cnt;
  logic        ovf;

  // Two's complement magnitude; 0x80000000 maps to itself, which the core reads as 2^31.
  function automatic logic [31:0] mag(input logic [31:0] v, input logic s);
    return (s && v[31]) ? -v : v;
  endfunction

`ifdef DIVCTRL_OVF_DETECT_EN
  assign ovf = sgn_q && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
`else
  assign ovf = 1'b0;
`endif

  // NOTE: every register here, datapath included, is updated with <= so all
  // reads within a cycle see the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      q_q           <= '0;
      r_q           <= '0;
      sgn_q         <= 1'b0;
      qneg          <= 1'b0;
      rneg          <= 1'b0;
      cnt           <= '0;
      hi            <= '0;
      lo            <= '0;
      core_dividend <= '0;
      core_divisor  <= '0;
      core_start    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      erro          <= 8'h00;
      timeout       <= 1'b0;
    end else begin
      core_start <= 1'b0;
      done       <= 1'b0;
      erro       <= 8'h00;
      timeout    <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            sgn_q <= is_signed;
            busy  <= 1'b1;
            state <= PREP;
          end
        end
        PREP: begin
          if (b_q == 32'h0 || ovf) begin
            done  <= 1'b1;
            erro  <= 8'hFF;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            core_dividend <= mag(a_q, sgn_q);
            core_divisor  <= mag(b_q, sgn_q);
            qneg          <= sgn_q & (a_q[31] ^ b_q[31]);
            rneg          <= sgn_q & a_q[31];
            core_start    <= 1'b1;
            state         <= LAUNCH;
          end
        end
        LAUNCH: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A result arriving on the final allowed cycle still wins over the abort.
          if (core_done) begin
            q_q   <= core_q;
            r_q   <= core_r;
            state <= FIX;
          end else if (cnt == CNT_LAST) begin
            done    <= 1'b1;
            timeout <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        FIX: begin
          lo    <= qneg ? -q_q : q_q;
          hi    <= rneg ? -r_q : r_q;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: a latency-programmable core model, a plain-arithmetic
// HI/LO reference model, and a monitor that checks every done pulse against the queue.
module tb_div_ctrl;

  localparam int TO = 10;

  logic        clk = 1'b0;
  logic        reset, start, is_signed, hi_we, lo_we;
  logic [31:0] a, b, wdata;
  logic [31:0] core_dividend, core_divisor, core_q, core_r, hi, lo;
  logic        core_start, core_done, busy, done, timeout;
  logic [7:0]  erro;

  div_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .core_dividend(core_dividend), .core_divisor(core_divisor), .core_start(core_start),
    .core_done(core_done), .core_q(core_q), .core_r(core_r),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .erro(erro), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [7:0]  erro;
    logic        tmo;
    int          c0;
    int          dcyc;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0, bad = 0, cyc = 0, cs_count = 0;
  int          core_lat = 1;
  bit          core_hang = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (core_start) cs_count <= cs_count + 1;

  // Core model: answers N cycles after the launch pulse, unless told to hang.
  initial begin
    logic [31:0] dd, dv;
    int          n;
    core_done = 1'b0; core_q = '0; core_r = '0;
    forever begin
      @(negedge clk);
      if (core_start && !core_hang) begin
        dd = core_dividend; dv = core_divisor; n = core_lat;
        repeat (n) @(posedge clk);
        #1;
        core_q    = (dv == 0) ? 32'h0 : dd / dv;
        core_r    = (dv == 0) ? dd : dd % dv;
        core_done = 1'b1;
        @(posedge clk);
        #1;
        core_done = 1'b0;
        core_q    = $urandom;
        core_r    = $urandom;
      end
    end
  end

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset && done) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", {31'b0, done}, 32'h0);
      end else begin
        e = sbq.pop_front();
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
        check("erro", {24'b0, erro}, {24'b0, e.erro});
        check("timeout", {31'b0, timeout}, {31'b0, e.tmo});
        check("done_cycle", cyc - e.c0 + 1, e.dcyc);
      end
    end
  end

  // Must be called at a negedge; returns one cycle into the operation.
  task automatic issue(input logic s, input logic [31:0] x, input logic [31:0] y, input int n,
                       input logic hw, input logic lw, input logic [31:0] wd, input bit hang);
    exp_t e;
    logic signed [31:0] sx, sy;
    if (hw) m_hi = wd;
    if (lw) m_lo = wd;
    e.hi = m_hi; e.lo = m_lo; e.erro = 8'h00; e.tmo = 1'b0; e.dcyc = n + 4;
    if (y == 32'h0) begin
      e.erro = 8'hFF; e.dcyc = 2;
    end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
`ifdef DIVCTRL_OVF_DETECT_EN
      e.erro = 8'hFF; e.dcyc = 2;
`else
      e.lo = 32'h8000_0000; e.hi = 32'h0;
`endif
    end else if (hang) begin
      e.tmo = 1'b1; e.dcyc = TO + 3;
    end else if (s) begin
      sx = x; sy = y;
      e.lo = sx / sy;
      e.hi = sx % sy;
    end else begin
      e.lo = x / y;
      e.hi = x % y;
    end
    m_hi = e.hi; m_lo = e.lo;
    core_lat = n; core_hang = hang;
    is_signed = s; a = x; b = y; hi_we = hw; lo_we = lw; wdata = wd; start = 1'b1;
    @(posedge clk);
    #1;
    e.c0 = cyc;
    sbq.push_back(e);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; a = $urandom; b = $urandom;
  endtask

  task automatic wait_done();
    int k = 0;
    while (k < 100) begin
      @(negedge clk);
      if (done) break;
      k++;
    end
    if (k == 100) check("done_wait_expired", {31'b0, done}, 32'h1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hi"}, hi, 32'h0);
    check({tag, "_lo"}, lo, 32'h0);
    check({tag, "_dividend"}, core_dividend, 32'h0);
    check({tag, "_divisor"}, core_divisor, 32'h0);
    check({tag, "_ctl"}, {27'b0, core_start, busy, done, timeout, 1'b0}, 32'h0);
    check({tag, "_erro"}, {24'b0, erro}, 32'h0);
  endtask

  initial begin
    int cs;
    logic        s;
    logic [31:0] x, y;
    reset = 1'b0; start = 1'b0; is_signed = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    a = '0; b = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    issue(1'b0, 32'd100, 32'd7, 3, 1'b0, 1'b0, 32'h0, 1'b0); wait_done();
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1, 1'b0, 1'b0, 32'h0, 1'b0); wait_done();
    issue(1'b1, 32'd7, 32'hFFFF_FFFE, 6, 1'b0, 1'b0, 32'h0, 1'b0); wait_done();

    // MTHI/MTLO preset, then divide by zero must leave them alone and never launch.
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    hi_we = 1'b0; lo_we = 1'b0;
    m_hi = 32'h1234_5678; m_lo = 32'h1234_5678;
    @(negedge clk);
    check("mthi", hi, 32'h1234_5678);
    check("mtlo", lo, 32'h1234_5678);
    cs = cs_count;
    issue(1'b1, 32'd55, 32'h0, 1, 1'b0, 1'b0, 32'h0, 1'b0); wait_done();
    issue(1'b0, 32'hFFFF_FFFF, 32'h0, 1, 1'b0, 1'b0, 32'h0, 1'b0); wait_done();
    @(negedge clk);
    check("div0_no_core_start", cs_count, cs);

    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 2, 1'b0, 1'b0, 32'h0, 1'b0); wait_done();

    // Hung core, then a start in the very cycle done is high.
    issue(1'b0, 32'd50, 32'd3, 1, 1'b0, 1'b0, 32'h0, 1'b1); wait_done();
    issue(1'b0, 32'd9, 32'd4, 2, 1'b0, 1'b0, 32'h0, 1'b0); wait_done();

    // Requests while busy are ignored.
    cs = cs_count;
    issue(1'b0, 32'd1000, 32'd10, 5, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("busy_high", {31'b0, busy}, 32'h1);
    start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF; a = 32'd1; b = 32'd0;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    wait_done();
    @(negedge clk);
    check("single_launch", cs_count - cs, 32'd1);

    // MTHI coinciding with start: write lands, divide by zero then keeps it.
    issue(1'b0, 32'd7, 32'h0, 1, 1'b1, 1'b0, 32'hCAFE_0001, 1'b0); wait_done();

    // Reset while waiting on the core.
    issue(1'b1, 32'd123, 32'hFFFF_FFFB, 8, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    sbq.delete();
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("post_reset_idle", {30'b0, busy, done}, 32'h0);

    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      x = $urandom;
      case ($urandom_range(0, 7))
        0:       y = 32'h0;
        1, 2:    y = 32'($urandom_range(1, 20));
        3:       y = -32'($urandom_range(1, 20));
        default: y = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) x = 32'($urandom_range(0, 300));
      issue(s, x, y, $urandom_range(1, 6), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 7) == 0), $urandom, 1'b0);
      wait_done();
    end

    @(negedge clk);
    check("scoreboard_empty", sbq.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got no finish want finish");
    $fatal(1, "time limit");
  end

endmodule
